player_ctrl: RTL and testbench
==============================

# player_ctrl

Sequencing controller for the player sprite. Sits between the raw keyboard decode and the player movement block. It gates the left/right arrow and super-speed controls into the mover, issues shot requests to the rope logic, and runs the hit/respawn/invulnerability life cycle. It also owns the lives counter and the game-over flag consumed by the top-level game FSM and the player drawing logic.

## Interface
- INIT_LIVES, 3: lives loaded at reset.
- HIT_FRAMES, 30: frames the player is frozen after a ball hit.
- INV_FRAMES, 60: invulnerable frames after the freeze.
- SPEED_FRAMES, 150: super-speed duration after a pickup.
- SHOT_TIMEOUT, 90: max frames spent in SHOOT without ropeDone.
- BLINK_LOG2, 2: blink half-period is 2^BLINK_LOG2 frames.

Ports:
- clk, in, 1: system clock.
- resetN, in, 1: asynchronous, active-low reset.
- startOfFrame, in, 1: one-clk pulse per video frame; all frame timers advance only on it.
- rightKey, in, 1: raw right key level.
- leftKey, in, 1: raw left key level.
- shootKey, in, 1: raw shoot key level.
- ballHit, in, 1: level; player/ball collision this clk.
- speedPickup, in, 1: one-clk pulse; super-speed power-up collected.
- ropeDone, in, 1: one-clk pulse; rope finished or was destroyed.
- rightArrow, out, 1: gated right command to the mover.
- leftArrow, out, 1: gated left command to the mover.
- superSpeed, out, 1: speed doubler to the mover.
- shotReq, out, 1: one-clk pulse; launch a rope.
- playerVisible, out, 1: draw enable (blink).
- lives, out, 3: remaining lives.
- gameOver, out, 1: sticky until reset.

## Operation
- States: ALIVE, SHOOT, HIT, INV, DEAD. Reset enters ALIVE.
- ALIVE, movement:
  - rightArrow = rightKey & ~leftKey; leftArrow = leftKey & ~rightKey.
  - Both keys pressed: both outputs 0.
- ALIVE, shooting:
  - A rising edge of shootKey (registered previous value; a held key does not repeat) moves the FSM to SHOOT.
  - shotReq pulses on the same clk edge as the transition.
- SHOOT:
  - Arrows forced 0.
  - ropeDone leads to ALIVE.
  - A frame counter reaching SHOT_TIMEOUT also leads to ALIVE.
- ballHit in ALIVE or SHOOT:
  - If lives > 1: decrement lives and go to HIT.
  - If lives == 1: lives becomes 0, gameOver becomes 1, go to DEAD.
  - ballHit wins over a simultaneous ropeDone or shoot edge; no shotReq is issued in that clk.
  - superSpeed timer cleared.
- HIT:
  - Arrows 0; ballHit, shoot and pickup are ignored.
  - After HIT_FRAMES startOfFrame pulses, go to INV.
- INV:
  - Movement is gated as in ALIVE; shooting is disabled; ballHit is ignored.
  - After INV_FRAMES pulses, go to ALIVE.
- DEAD:
  - Terminal. All outputs 0 except gameOver = 1 and playerVisible = 1.
  - All inputs are ignored; only reset leaves DEAD.
- Super-speed:
  - speedPickup in ALIVE, SHOOT or INV loads the speed counter to SPEED_FRAMES.
  - A pickup while the counter is already active reloads it (no accumulation).
  - superSpeed = (counter != 0).
  - The counter decrements on startOfFrame and saturates at 0.
- Blink:
  - In HIT and INV, playerVisible = ~frameCnt[BLINK_LOG2].
  - In all other states playerVisible = 1.
- The state frame counter clears on every state change.

## Timing
- Reset values:
  - State ALIVE; lives = INIT_LIVES; gameOver 0.
  - rightArrow, leftArrow, superSpeed and shotReq 0; playerVisible 1.
  - All counters 0; shoot-edge register 0.
- All outputs are registered: one clk latency from the inputs.
- The shootKey edge is detected per clk, not per frame.
- Timer expiry:
  - Checked when startOfFrame arrives with counter == limit-1.
  - The transition occurs on that clk.
- An asynchronous reset at any time, including mid-HIT or mid-SHOOT, returns everything to the reset values immediately.
- Counter widths: 8 bits is sufficient for the defaults; size each counter with $clog2(limit+1).

## Structure
- player_pkg holds:
  - The state enum: ALIVE, SHOOT, HIT, INV, DEAD.
  - Default constants for lives and frame counts.
- Sub-module frame_timer:
  - Inputs: load value, load strobe, startOfFrame.
  - Output: done.
  - Instantiated for the state timer and the speed timer.

## Test plan
- Reset, then hold rightKey: rightArrow = 1 one clk later. Add leftKey: both arrows 0.
- shootKey held for 100 clks: exactly one shotReq pulse; state SHOOT with arrows 0. ropeDone returns to ALIVE; with no ropeDone, the FSM returns to ALIVE after 90 frames.
- ballHit with lives = 3: lives = 2, HIT. playerVisible toggles every 4 frames. INV is entered after 30 frames and ALIVE after 60 more. A ballHit during INV leaves lives = 2.
- Three hits separated by the recovery time: lives 3, 2, 1, 0; gameOver = 1 and the FSM stays in DEAD; keys produce no arrows.
- speedPickup: superSpeed = 1 for 150 frames. A second pickup at frame 100 extends it to frame 250. A ballHit clears superSpeed immediately.
- Reset asserted mid-HIT: lives = 3, state ALIVE, playerVisible = 1.

Source files
------------

// File: rtl/player_pkg.sv
// player_pkg: shared definitions for the player sequencing controller.
// Holds the life-cycle state encoding, the default frame/lives constants
// used as parameter defaults by player_ctrl, and a small sizing helper.
package player_pkg;

    // Player life-cycle states; dbg_state on the interface carries this type.
    typedef enum logic [2:0] {
        ALIVE = 3'd0,
        SHOOT = 3'd1,
        HIT   = 3'd2,
        INV   = 3'd3,
        DEAD  = 3'd4
    } player_state_e;

    localparam int DEF_INIT_LIVES   = 3;
    localparam int DEF_HIT_FRAMES   = 30;
    localparam int DEF_INV_FRAMES   = 60;
    localparam int DEF_SPEED_FRAMES = 150;
    localparam int DEF_SHOT_TIMEOUT = 90;
    localparam int DEF_BLINK_LOG2   = 2;

    // Largest of three frame limits; sizes the shared state timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/player_ctrl_if.sv
// player_ctrl_if: bundles the keyboard/game-event inputs and the mover,
// rope, draw and game-FSM outputs of player_ctrl.
//   slave  : the controller (consumes inputs, drives outputs)
//   master : the surrounding game logic / testbench
// Pulse protocol: startOfFrame, speedPickup, ropeDone and shotReq are
// single-clk strobes sampled on the rising clock edge; every other signal is
// a level. There is no back-pressure: a strobe is consumed in the clk it is
// high, or ignored if the current state does not accept it.
interface player_ctrl_if;
    import player_pkg::*;

    logic          startOfFrame;
    logic          rightKey;
    logic          leftKey;
    logic          shootKey;
    logic          ballHit;
    logic          speedPickup;
    logic          ropeDone;

    logic          rightArrow;
    logic          leftArrow;
    logic          superSpeed;
    logic          shotReq;
    logic          playerVisible;
    logic [2:0]    lives;
    logic          gameOver;
    player_state_e dbg_state;

    modport slave (
        input  startOfFrame, rightKey, leftKey, shootKey, ballHit,
               speedPickup, ropeDone,
        output rightArrow, leftArrow, superSpeed, shotReq, playerVisible,
               lives, gameOver, dbg_state
    );

    modport master (
        output startOfFrame, rightKey, leftKey, shootKey, ballHit,
               speedPickup, ropeDone,
        input  rightArrow, leftArrow, superSpeed, shotReq, playerVisible,
               lives, gameOver, dbg_state
    );

endinterface

// File: rtl/player_ctrl_frame_timer.sv
// frame_timer: loadable down-counter stepped by the start-of-frame strobe.
//   load / load_val : reload the count (wins over a same-clk frame step)
//   start_of_frame  : decrement, saturating at zero
//   cnt_nxt         : the value the counter takes at this clock edge
//   done            : this frame strobe is the last one of the loaded span
//                     (count is 1 and a frame step arrives)
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         start_of_frame,
    output logic [W-1:0] cnt_nxt,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (start_of_frame && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Depends only on the flop and the strobe, never on load, so the owner
    // can use it to pick the next state without forming a loop.
    assign done    = start_of_frame && (cnt_q == W'(1));
    assign cnt_nxt = cnt_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// player_ctrl: player sprite sequencing controller.
// Gates arrow keys into the mover, issues rope shot requests, runs the
// ALIVE/SHOOT/HIT/INV/DEAD life cycle, owns lives, game-over and the
// super-speed timer. All outputs are flops (one clk after the inputs).
//   clk, resetN : clock, asynchronous active-low reset
//   bus         : player_ctrl_if.slave (inputs, outputs, dbg_state)
module player_ctrl
    import player_pkg::*;
#(
    parameter int INIT_LIVES   = DEF_INIT_LIVES,
    parameter int HIT_FRAMES   = DEF_HIT_FRAMES,
    parameter int INV_FRAMES   = DEF_INV_FRAMES,
    parameter int SPEED_FRAMES = DEF_SPEED_FRAMES,
    parameter int SHOT_TIMEOUT = DEF_SHOT_TIMEOUT,
    parameter int BLINK_LOG2   = DEF_BLINK_LOG2
) (
    input logic           clk,
    input logic           resetN,
    player_ctrl_if.slave  bus
);

    localparam int ST_W  = $clog2(max3(HIT_FRAMES, INV_FRAMES, SHOT_TIMEOUT) + 1);
    localparam int SPD_W = $clog2(SPEED_FRAMES + 1);

    localparam logic [ST_W-1:0]  HIT_L     = ST_W'(HIT_FRAMES);
    localparam logic [ST_W-1:0]  INV_L     = ST_W'(INV_FRAMES);
    localparam logic [ST_W-1:0]  SHOT_L    = ST_W'(SHOT_TIMEOUT);
    localparam logic [SPD_W-1:0] SPD_L     = SPD_W'(SPEED_FRAMES);
    localparam logic [2:0]       LIVES_RST = 3'(INIT_LIVES);

    // Frame span of each timed state; the timer is reloaded with this on
    // entry, which doubles as "clear the state frame counter".
    function automatic logic [ST_W-1:0] state_limit(input player_state_e s);
        case (s)
            SHOOT:   return SHOT_L;
            HIT:     return HIT_L;
            INV:     return INV_L;
            default: return '0;
        endcase
    endfunction

    player_state_e state_q, state_d;
    logic [2:0]    lives_q, lives_d;
    logic          game_over_q, game_over_d;
    logic          shoot_prev_q;
    logic          right_arrow_q, right_arrow_d;
    logic          left_arrow_q, left_arrow_d;
    logic          super_speed_q, super_speed_d;
    logic          shot_req_q, shot_req_d;
    logic          visible_q, visible_d;

    logic             hit_take;
    logic             shoot_edge;
    logic             move_en;
    logic             st_load;
    logic [ST_W-1:0]  st_load_val;
    logic [ST_W-1:0]  st_nxt;
    logic             st_done;
    logic [ST_W-1:0]  st_elapsed;
    logic             spd_load;
    logic [SPD_W-1:0] spd_load_val;
    logic [SPD_W-1:0] spd_nxt;
    logic             spd_done;

    frame_timer #(.W(ST_W)) u_state_timer (
        .clk            (clk),
        .resetN         (resetN),
        .load           (st_load),
        .load_val       (st_load_val),
        .start_of_frame (bus.startOfFrame),
        .cnt_nxt        (st_nxt),
        .done           (st_done)
    );

    frame_timer #(.W(SPD_W)) u_speed_timer (
        .clk            (clk),
        .resetN         (resetN),
        .load           (spd_load),
        .load_val       (spd_load_val),
        .start_of_frame (bus.startOfFrame),
        .cnt_nxt        (spd_nxt),
        .done           (spd_done)
    );

    // Next state, lives, game-over and timer reloads.
    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        game_over_d  = game_over_q;
        shot_req_d   = 1'b0;
        spd_load     = 1'b0;
        spd_load_val = '0;
        hit_take     = bus.ballHit && ((state_q == ALIVE) || (state_q == SHOOT));
        shoot_edge   = bus.shootKey && !shoot_prev_q;

        case (state_q)
            ALIVE: begin
                if (!hit_take && shoot_edge) begin
                    state_d    = SHOOT;
                    shot_req_d = 1'b1;
                end
            end
            SHOOT: begin
                if (!hit_take && (bus.ropeDone || st_done)) begin
                    state_d = ALIVE;
                end
            end
            HIT: begin
                if (st_done) begin
                    state_d = INV;
                end
            end
            INV: begin
                if (st_done) begin
                    state_d = ALIVE;
                end
            end
            DEAD:    state_d = DEAD;
            default: state_d = ALIVE;
        endcase

        // A hit overrides whatever the case above chose this clk.
        if (hit_take) begin
            spd_load     = 1'b1;
            spd_load_val = '0;
            if (lives_q > 3'd1) begin
                lives_d = lives_q - 3'd1;
                state_d = HIT;
            end else begin
                lives_d     = '0;
                game_over_d = 1'b1;
                state_d     = DEAD;
            end
        end else if (bus.speedPickup &&
                     ((state_q == ALIVE) || (state_q == SHOOT) || (state_q == INV))) begin
            spd_load     = 1'b1;
            spd_load_val = SPD_L;
        end

        st_load     = (state_d != state_q);
        st_load_val = state_limit(state_d);
    end

    // Output terms, evaluated against the state and counts being registered
    // this edge so outputs always agree with dbg_state.
    always_comb begin
        move_en       = (state_d == ALIVE) || (state_d == INV);
        right_arrow_d = move_en && bus.rightKey && !bus.leftKey;
        left_arrow_d  = move_en && bus.leftKey && !bus.rightKey;
        super_speed_d = (spd_nxt != '0);
        st_elapsed    = state_limit(state_d) - st_nxt;
        if ((state_d == HIT) || (state_d == INV)) begin
            visible_d = !st_elapsed[BLINK_LOG2];
        end else begin
            visible_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ALIVE;
            lives_q       <= LIVES_RST;
            game_over_q   <= 1'b0;
            shoot_prev_q  <= 1'b0;
            right_arrow_q <= 1'b0;
            left_arrow_q  <= 1'b0;
            super_speed_q <= 1'b0;
            shot_req_q    <= 1'b0;
            visible_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            game_over_q   <= game_over_d;
            shoot_prev_q  <= bus.shootKey;
            right_arrow_q <= right_arrow_d;
            left_arrow_q  <= left_arrow_d;
            super_speed_q <= super_speed_d;
            shot_req_q    <= shot_req_d;
            visible_q     <= visible_d;
        end
    end

    assign bus.rightArrow    = right_arrow_q;
    assign bus.leftArrow     = left_arrow_q;
    assign bus.superSpeed    = super_speed_q;
    assign bus.shotReq       = shot_req_q;
    assign bus.playerVisible = visible_q;
    assign bus.lives         = lives_q;
    assign bus.gameOver      = game_over_q;
    assign bus.dbg_state     = state_q;

    // Speed expiry is read from the count itself; only one elapsed bit
    // drives the blink.
    logic unused_ok;
    assign unused_ok = ^{1'b0, spd_done, st_elapsed};

endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: directed scoreboard bench for player_ctrl.
// The driver applies stimulus and pushes hand-computed expected output
// snapshots into exp_q; the monitor pops and compares on the falling edge
// whenever the driver marks a snapshot as due.
module tb_player_ctrl;
    import player_pkg::*;

    typedef struct packed {
        player_state_e st;
        logic          r;
        logic          l;
        logic          ss;
        logic          sh;
        logic          v;
        logic [2:0]    lives;
        logic          go;
        logic [7:0]    shots;
    } obs_t;

    logic clk = 1'b0;
    logic resetN;

    player_ctrl_if bus ();

    player_ctrl dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    obs_t  exp_q[$];
    string name_q[$];
    logic  chk_v     = 1'b0;
    logic  done_flag = 1'b0;
    int    checks    = 0;
    int    errors    = 0;
    int    shots_seen = 0;
    int    exp_shots  = 0;

    // ---------------- clock / reset helpers and driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        chk_v = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.startOfFrame = 1'b1;
            tick();
            bus.startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic expect_obs(input obs_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_v = 1'b1;
    endtask

    task automatic clear_inputs();
        bus.startOfFrame = 1'b0;
        bus.rightKey     = 1'b0;
        bus.leftKey      = 1'b0;
        bus.shootKey     = 1'b0;
        bus.ballHit      = 1'b0;
        bus.speedPickup  = 1'b0;
        bus.ropeDone     = 1'b0;
    endtask

    function automatic obs_t mk(input player_state_e st, input logic r, input logic l,
                                input logic ss, input logic sh, input logic v,
                                input int lv, input logic go);
        obs_t o;
        o.st    = st;
        o.r     = r;
        o.l     = l;
        o.ss    = ss;
        o.sh    = sh;
        o.v     = v;
        o.lives = 3'(lv);
        o.go    = go;
        o.shots = 8'(exp_shots);
        return o;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        obs_t  got;
        obs_t  e;
        string nm;
        if (bus.shotReq === 1'b1) shots_seen++;
        if (chk_v) begin
            got.st    = bus.dbg_state;
            got.r     = bus.rightArrow;
            got.l     = bus.leftArrow;
            got.ss    = bus.superSpeed;
            got.sh    = bus.shotReq;
            got.v     = bus.playerVisible;
            got.lives = bus.lives;
            got.go    = bus.gameOver;
            got.shots = 8'(shots_seen);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample got st=%0d with no expected entry", got.st);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s got st=%0d r=%b l=%b ss=%b sh=%b vis=%b lives=%0d go=%b shots=%0d required st=%0d r=%b l=%b ss=%b sh=%b vis=%b lives=%0d go=%b shots=%0d",
                             nm, got.st, got.r, got.l, got.ss, got.sh, got.v, got.lives, got.go, got.shots,
                             e.st, e.r, e.l, e.ss, e.sh, e.v, e.lives, e.go, e.shots);
                end
            end
        end
        if (done_flag) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL queue_drain got %0d pending required 0", exp_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no end of test required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        resetN = 1'b0;
        clear_inputs();
        tick();
        tick();
        expect_obs(mk(ALIVE, 0, 0, 0, 0, 1, 3, 0), "reset_values");
        tick();
        resetN = 1'b1;
        tick();

        // Movement gating.
        bus.rightKey = 1'b1;
        tick();
        expect_obs(mk(ALIVE, 1, 0, 0, 0, 1, 3, 0), "right_only");
        bus.leftKey = 1'b1;
        tick();
        expect_obs(mk(ALIVE, 0, 0, 0, 0, 1, 3, 0), "both_keys");
        bus.rightKey = 1'b0;
        tick();
        expect_obs(mk(ALIVE, 0, 1, 0, 0, 1, 3, 0), "left_only");
        bus.leftKey = 1'b0;
        tick();

        // Shoot edge with a held key, right held to show arrows forced off.
        bus.rightKey = 1'b1;
        bus.shootKey = 1'b1;
        tick();
        exp_shots = 1;
        expect_obs(mk(SHOOT, 0, 0, 0, 1, 1, 3, 0), "shoot_edge");
        repeat (99) tick();
        expect_obs(mk(SHOOT, 0, 0, 0, 0, 1, 3, 0), "shoot_held_one_pulse");
        bus.ropeDone = 1'b1;
        tick();
        bus.ropeDone = 1'b0;
        expect_obs(mk(ALIVE, 1, 0, 0, 0, 1, 3, 0), "rope_done");
        tick();
        expect_obs(mk(ALIVE, 1, 0, 0, 0, 1, 3, 0), "held_no_repeat");
        bus.shootKey = 1'b0;
        tick();
        bus.shootKey = 1'b1;
        tick();
        exp_shots = 2;
        expect_obs(mk(SHOOT, 0, 0, 0, 1, 1, 3, 0), "second_shot");
        frames(89);
        expect_obs(mk(SHOOT, 0, 0, 0, 0, 1, 3, 0), "timeout_minus1");
        frames(1);
        expect_obs(mk(ALIVE, 1, 0, 0, 0, 1, 3, 0), "shot_timeout");
        bus.shootKey = 1'b0;
        tick();

        // Hit, blink, invulnerability.
        bus.ballHit = 1'b1;
        tick();
        bus.ballHit = 1'b0;
        expect_obs(mk(HIT, 0, 0, 0, 0, 1, 2, 0), "hit_lives2");
        frames(4);
        expect_obs(mk(HIT, 0, 0, 0, 0, 0, 2, 0), "blink_off_f4");
        frames(4);
        expect_obs(mk(HIT, 0, 0, 0, 0, 1, 2, 0), "blink_on_f8");
        bus.ballHit = 1'b1;
        tick();
        bus.ballHit = 1'b0;
        expect_obs(mk(HIT, 0, 0, 0, 0, 1, 2, 0), "hit_ignored_in_hit");
        frames(21);
        expect_obs(mk(HIT, 0, 0, 0, 0, 0, 2, 0), "hit_f29");
        frames(1);
        expect_obs(mk(INV, 1, 0, 0, 0, 1, 2, 0), "enter_inv");
        bus.ballHit = 1'b1;
        tick();
        bus.ballHit = 1'b0;
        expect_obs(mk(INV, 1, 0, 0, 0, 1, 2, 0), "inv_hit_ignored");
        bus.shootKey = 1'b1;
        tick();
        bus.shootKey = 1'b0;
        expect_obs(mk(INV, 1, 0, 0, 0, 1, 2, 0), "inv_no_shoot");
        frames(59);
        expect_obs(mk(INV, 1, 0, 0, 0, 1, 2, 0), "inv_f59");
        frames(1);
        expect_obs(mk(ALIVE, 1, 0, 0, 0, 1, 2, 0), "back_alive");
        bus.rightKey = 1'b0;
        tick();

        // Super-speed load, reload, expiry.
        bus.speedPickup = 1'b1;
        tick();
        bus.speedPickup = 1'b0;
        expect_obs(mk(ALIVE, 0, 0, 1, 0, 1, 2, 0), "pickup");
        frames(100);
        expect_obs(mk(ALIVE, 0, 0, 1, 0, 1, 2, 0), "speed_f100");
        bus.speedPickup = 1'b1;
        tick();
        bus.speedPickup = 1'b0;
        frames(149);
        expect_obs(mk(ALIVE, 0, 0, 1, 0, 1, 2, 0), "speed_f249");
        frames(1);
        expect_obs(mk(ALIVE, 0, 0, 0, 0, 1, 2, 0), "speed_f250_off");

        // Hit clears speed; pickup ignored in HIT.
        bus.speedPickup = 1'b1;
        tick();
        bus.speedPickup = 1'b0;
        frames(10);
        bus.ballHit = 1'b1;
        tick();
        bus.ballHit = 1'b0;
        expect_obs(mk(HIT, 0, 0, 0, 0, 1, 1, 0), "hit_clears_speed");
        bus.speedPickup = 1'b1;
        tick();
        bus.speedPickup = 1'b0;
        expect_obs(mk(HIT, 0, 0, 0, 0, 1, 1, 0), "pickup_ignored_hit");
        frames(30);
        frames(60);
        expect_obs(mk(ALIVE, 0, 0, 0, 0, 1, 1, 0), "recovered_lives1");

        // Last life: hit beats a simultaneous shoot edge and ropeDone.
        bus.shootKey = 1'b1;
        bus.ropeDone = 1'b1;
        bus.ballHit  = 1'b1;
        tick();
        clear_inputs();
        expect_obs(mk(DEAD, 0, 0, 0, 0, 1, 0, 1), "hit_beats_shot_dead");
        bus.rightKey    = 1'b1;
        bus.speedPickup = 1'b1;
        bus.ballHit     = 1'b1;
        bus.ropeDone    = 1'b1;
        tick();
        bus.shootKey = 1'b1;
        frames(5);
        expect_obs(mk(DEAD, 0, 0, 0, 0, 1, 0, 1), "dead_sticky");
        tick();

        // Asynchronous resets: each check samples before any clock edge.
        clear_inputs();
        resetN = 1'b0;
        expect_obs(mk(ALIVE, 0, 0, 0, 0, 1, 3, 0), "reset_from_dead");
        tick();
        resetN = 1'b1;
        tick();
        bus.ballHit = 1'b1;
        tick();
        bus.ballHit = 1'b0;
        expect_obs(mk(HIT, 0, 0, 0, 0, 1, 2, 0), "hit_after_reset");
        frames(3);
        resetN = 1'b0;
        expect_obs(mk(ALIVE, 0, 0, 0, 0, 1, 3, 0), "reset_mid_hit");
        tick();
        resetN = 1'b1;
        tick();
        bus.shootKey = 1'b1;
        tick();
        bus.shootKey = 1'b0;
        exp_shots = 3;
        expect_obs(mk(SHOOT, 0, 0, 0, 1, 1, 3, 0), "shoot_after_reset");
        frames(5);
        resetN = 1'b0;
        expect_obs(mk(ALIVE, 0, 0, 0, 0, 1, 3, 0), "reset_mid_shoot");
        tick();
        resetN = 1'b1;
        tick();

        done_flag = 1'b1;
        tick();
        tick();
    end

endmodule
